wbrd2axilm: RTL

- Bridges a pipelined Wishbone read slave port to a single AXI-lite read master channel pair (AR/R).
- Sits between a Wishbone bus master (CPU/DMA) and an AXI-lite interconnect.
- Converts WB stb/ack/err reads into AR/R transactions, with up to 2^LGFIFO reads in flight.
- Discards responses belonging to aborted or errored bus cycles.

---
 rtl/wbrd2axilm.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wbrd2axilm.sv
// Pipelined Wishbone read slave to AXI-lite AR/R master bridge with abort/error flush.
// Optional macro WBRD2AXILM_WRITE_ERR_EN: WB writes are answered with a bus error instead of a read.
module wbrd2axilm #(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 28,
  parameter int unsigned AXILLSB          = $clog2(C_AXI_DATA_WIDTH/8),
  parameter int unsigned LGFIFO           = 3,
  localparam int unsigned AW = C_AXI_ADDR_WIDTH - AXILLSB,
  localparam int unsigned DW = C_AXI_DATA_WIDTH
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_wb_cyc,
  input  logic                        i_wb_stb,
  input  logic                        i_wb_we,
  input  logic [AW-1:0]               i_wb_addr,
  input  logic [DW-1:0]               i_wb_data,
  input  logic [DW/8-1:0]             i_wb_sel,
  output logic                        o_wb_stall,
  output logic                        o_wb_ack,
  output logic [DW-1:0]               o_wb_data,
  output logic                        o_wb_err,
  output logic                        o_axi_arvalid,
  input  logic                        i_axi_arready,
  output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_araddr,
  output logic [2:0]                  o_axi_arprot,
  input  logic                        i_axi_rvalid,
  output logic                        o_axi_rready,
  input  logic [DW-1:0]               i_axi_rdata,
  input  logic [1:0]                  i_axi_rresp
);

  localparam int unsigned CW = LGFIFO + 1;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   r_count;
  logic            r_flush, r_full, accept, rd_accept, r_beat, resp_ok;
  logic            werr_hold, werr_fire, err_next;

  assign o_axi_arprot = 3'b000;
  assign o_axi_rready = 1'b1;

  assign r_flush    = (state == ST_FLUSH);
  assign r_full     = (r_count == CW'(2**LGFIFO));
  assign o_wb_stall = r_flush || r_full || (o_axi_arvalid && !i_axi_arready) || werr_hold;
  assign accept     = i_wb_cyc && i_wb_stb && !o_wb_stall;
  // Beats with nothing outstanding are protocol violations and are dropped.
  assign r_beat     = i_axi_rvalid && (r_count != '0);
  assign resp_ok    = r_beat && i_wb_cyc && !r_flush;

`ifdef WBRD2AXILM_WRITE_ERR_EN
  logic r_werr;

  assign rd_accept = accept && !i_wb_we;
  assign werr_hold = r_werr;
  assign werr_fire = r_werr && i_wb_cyc && !r_flush && (r_count == '0) && !o_axi_arvalid;

  // Pending write error waits for all earlier reads to return.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_werr <= 1'b0;
    else if (accept && i_wb_we)
      r_werr <= 1'b1;
    else if (!i_wb_cyc || r_flush || werr_fire)
      r_werr <= 1'b0;
  end

  logic unused;
  assign unused = &{1'b0, i_wb_data, i_wb_sel, i_axi_rresp[0]};
`else
  assign rd_accept = accept;
  assign werr_hold = 1'b0;
  assign werr_fire = 1'b0;

  logic unused;
  assign unused = &{1'b0, i_wb_we, i_wb_data, i_wb_sel, i_axi_rresp[0]};
`endif

  assign err_next = (resp_ok && i_axi_rresp[1]) || werr_fire;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      state <= ST_RUN;
    else
      state <= state_next;
  end

  // Flush on abort or error; leave once nothing is outstanding.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN:
        if (err_next || (!i_wb_cyc && ((r_count != '0) || o_axi_arvalid)))
          state_next = ST_FLUSH;
      ST_FLUSH:
        if ((r_count == '0) && !o_axi_arvalid)
          state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_count <= '0;
    else begin
      case ({rd_accept, r_beat})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // AR request held until the interconnect takes it, regardless of cyc.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_axi_arvalid <= 1'b0;
      o_axi_araddr  <= '0;
    end else if (rd_accept) begin
      o_axi_arvalid <= 1'b1;
      o_axi_araddr  <= {i_wb_addr, AXILLSB'(0)};
    end else if (i_axi_arready) begin
      o_axi_arvalid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= resp_ok && !i_axi_rresp[1];
      o_wb_err <= err_next;
      if (resp_ok)
        o_wb_data <= i_axi_rdata;
    end
  end

endmodule
